sine_rom_sched: RTL and testbench
=================================

Name: sine_rom_sched

Overview:
Two-channel sine sample scheduler that time-multiplexes one single-port, registered-output sine ROM (1-cycle read latency, contents from sinsrom.mem).
Each channel has a phase accumulator with its own frequency increment; channel 1 adds a programmable phase offset.
On each sample tick the block issues both ROM reads back-to-back, then presents a coherent sample pair with a one-cycle valid strobe.
It sits between the sample-rate timer and the ROM, and feeds the output/DAC stage.

Parameters:
ADDRESS_WIDTH, 8, ROM address width; ROM depth is 2**ADDRESS_WIDTH.
DATA_WIDTH, 8, ROM sample width.
PHASE_WIDTH, 16, accumulator width; must be >= ADDRESS_WIDTH.

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst_n  in  1  asynchronous reset, active-low
en  in  1  enables tick acceptance
tick  in  1  sample request, one-cycle pulse
phase_clr  in  1  zeroes both accumulators; honoured only in IDLE
incr0  in  PHASE_WIDTH  channel 0 phase step
incr1  in  PHASE_WIDTH  channel 1 phase step
offset1  in  ADDRESS_WIDTH  channel 1 address offset
clr_overrun  in  1  clears the sticky overrun flag
rom_addr  out  ADDRESS_WIDTH  registered address to the ROM
rom_dout  in  DATA_WIDTH  ROM registered read data
dout0  out  DATA_WIDTH  channel 0 sample
dout1  out  DATA_WIDTH  channel 1 sample
valid  out  1  one-cycle pulse when dout0/dout1 update
busy  out  1  high when state != IDLE
overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; phase0, phase1, rom_addr, dout0, dout1, the hold register, valid and overrun all 0.
- addr0 = phase0[PHASE_WIDTH-1 -: ADDRESS_WIDTH].
- addr1 = (phase1[PHASE_WIDTH-1 -: ADDRESS_WIDTH] + offset1) mod 2**ADDRESS_WIDTH.
- FSM states: IDLE, A0, A1, C1.
- IDLE: on an edge with tick=1 and en=1: rom_addr<=addr0; go to A0.
- If phase_clr=1 on that same edge, addr0 and addr1 are computed from zero phases, and both phases are cleared.
- IDLE with phase_clr=1 and no accepted tick: phase0 and phase1 <= 0.
- A0 (addr0 on bus): rom_addr<=addr1; go to A1.
- A1 (rom_dout = sample0): hold register <= rom_dout; go to C1.
- C1 (rom_dout = sample1): dout0<=hold; dout1<=rom_dout; valid<=1 for one cycle.
- Also in C1: phase0<=phase0+incr0 and phase1<=phase1+incr1, mod 2**PHASE_WIDTH, using incr values sampled on this edge; then go to IDLE.
- Latency: tick accepted at edge k gives valid high during the cycle after edge k+3. Back-to-back ticks can be accepted every 4 cycles.
- dout0 and dout1 always update together; they hold their values between valid pulses.
- Tick while busy: the tick is dropped, overrun<=1, and the sequence is unaffected.
- Tick in IDLE with en=0: ignored, no overrun.
- Set and clear of overrun on the same edge: set wins.
- en deasserted mid-sequence: the sequence completes normally.
- phase_clr while busy: ignored; it is not deferred.
- offset1 is sampled only at the IDLE->A0 edge.
- rom_addr holds its last value in IDLE.
- Reset asserted mid-sequence: immediate return to reset values, no valid pulse.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0, busy=0, rom_addr=0.
2. ROM loaded with rom[i]=i; incr0=0x0100, incr1=0x0200, offset1=0x40; tick at edge k -> busy for cycles k+1..k+3; rom_addr=0x00 then 0x40; valid one cycle after edge k+3 with dout0=0x00, dout1=0x40. Second tick -> dout0=0x01, dout1=0x42.
3. Wrap: incr0=0x8000; three ticks -> dout0 = 0x00, 0x80, 0x00. offset1=0xC0 with phase1 top byte 0x80 -> dout1=0x40.
4. Overrun: tick, then a second tick while state=A0 -> overrun=1, exactly one valid pulse. clr_overrun together with a new tick during C1 -> overrun stays 1. Later clr_overrun alone -> overrun=0.
5. en=0 with a tick -> no busy, no valid, overrun=0. phase_clr with tick in IDLE after 3 advances -> dout0=0x00.
6. rst_n pulsed low during A1 -> outputs 0 immediately. Next tick -> dout0=0x00, dout1=offset1.

Source files
------------

// File: rtl/sine_rom_sched.sv
// Two-channel sine sample scheduler sharing one registered-output ROM.
// Each accepted tick reads channel 0, then channel 1, and emits a coherent sample pair.
module sine_rom_sched #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int PHASE_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     tick,
    input  logic                     phase_clr,
    input  logic [PHASE_WIDTH-1:0]   incr0,
    input  logic [PHASE_WIDTH-1:0]   incr1,
    input  logic [ADDRESS_WIDTH-1:0] offset1,
    input  logic                     clr_overrun,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic [DATA_WIDTH-1:0]    dout0,
    output logic [DATA_WIDTH-1:0]    dout1,
    output logic                     valid,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {S_IDLE, S_A0, S_A1, S_C1} state_t;

    state_t                   r_state, w_next;
    logic [PHASE_WIDTH-1:0]   r_phase0, r_phase1;
    logic [ADDRESS_WIDTH-1:0] r_rom_addr, r_addr1;
    logic [DATA_WIDTH-1:0]    r_hold, r_dout0, r_dout1;
    logic                     r_valid, r_overrun;
    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_addr0, w_addr1, w_top1;

    assign w_accept = (r_state == S_IDLE) && tick && en;

    // A phase clear coinciding with the accepted tick addresses from zero phase.
    assign w_addr0 = phase_clr ? '0 : r_phase0[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
    assign w_top1  = phase_clr ? '0 : r_phase1[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
    assign w_addr1 = w_top1 + offset1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_A0;
            S_A0:    w_next = S_A1;
            S_A1:    w_next = S_C1;
            S_C1:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase0   <= '0;
            r_phase1   <= '0;
            r_rom_addr <= '0;
            r_addr1    <= '0;
            r_hold     <= '0;
            r_dout0    <= '0;
            r_dout1    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (phase_clr) begin
                        r_phase0 <= '0;
                        r_phase1 <= '0;
                    end
                    if (w_accept) begin
                        r_rom_addr <= w_addr0;
                        r_addr1    <= w_addr1;
                    end
                end
                S_A0: r_rom_addr <= r_addr1;
                S_A1: r_hold <= rom_dout;
                S_C1: begin
                    r_dout0  <= r_hold;
                    r_dout1  <= rom_dout;
                    r_valid  <= 1'b1;
                    r_phase0 <= r_phase0 + incr0;
                    r_phase1 <= r_phase1 + incr1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun; a dropped tick beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_overrun <= 1'b0;
        else if (tick && r_state != S_IDLE)    r_overrun <= 1'b1;
        else if (clr_overrun)                  r_overrun <= 1'b0;
    end

    assign rom_addr = r_rom_addr;
    assign dout0    = r_dout0;
    assign dout1    = r_dout1;
    assign valid    = r_valid;
    assign busy     = (r_state != S_IDLE);
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_sine_rom_sched.sv
// Bench for sine_rom_sched: external ROM model plus a phase-accumulator reference model.
module tb_sine_rom_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        tick = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] incr0 = '0;
    logic [15:0] incr1 = '0;
    logic [7:0]  offset1 = '0;
    logic        clr_overrun = 1'b0;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_dout = '0;
    logic [7:0]  dout0, dout1;
    logic        valid, busy, overrun;

    logic [7:0]  rom [256];
    int          nchk = 0;
    int          nerr = 0;

    // Reference state: phases, sticky flag and last emitted pair.
    int unsigned m_ph0 = 0, m_ph1 = 0;
    bit          m_ovr = 1'b0;
    logic [7:0]  m_d0 = '0, m_d1 = '0;

    sine_rom_sched #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .PHASE_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .phase_clr(phase_clr),
        .incr0(incr0), .incr1(incr1), .offset1(offset1), .clr_overrun(clr_overrun),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .dout0(dout0), .dout1(dout1),
        .valid(valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_d0"}, dout0, m_d0);
        chk({tag, "_d1"}, dout1, m_d1);
        chk({tag, "_ovr"}, overrun, m_ovr);
    endtask

    // One full sample sequence starting at a negedge with the DUT idle.
    // inj_stage 0..2 injects an extra tick at the A0/A1/C1 edge (-1: none).
    task automatic seq(input bit clr, input int inj_stage, input bit inj_clr_ovr,
                       input bit drop_en, input bit busy_pclr);
        logic [7:0] a0, a1;
        if (clr) begin m_ph0 = 0; m_ph1 = 0; end
        a0 = 8'((m_ph0 >> 8) & 32'hff);
        a1 = 8'(((m_ph1 >> 8) + offset1) & 32'hff);
        tick = 1'b1; phase_clr = clr; en = 1'b1;
        @(negedge clk);
        chk("seq_busy_a0", busy, 1);
        chk("seq_addr0", rom_addr, a0);
        chk("seq_valid_a0", valid, 0);
        for (int s = 0; s < 3; s++) begin
            tick = (inj_stage == s);
            clr_overrun = inj_clr_ovr && (inj_stage == s);
            en = !drop_en;
            phase_clr = busy_pclr;
            @(negedge clk);
            if (s == 0) chk("seq_addr1", rom_addr, a1);
            if (s < 2) begin
                chk("seq_busy_mid", busy, 1);
                chk("seq_valid_mid", valid, 0);
            end
        end
        tick = 1'b0; clr_overrun = 1'b0; en = 1'b1; phase_clr = 1'b0;
        if (inj_stage >= 0) m_ovr = 1'b1;
        m_d0 = rom[a0];
        m_d1 = rom[a1];
        m_ph0 = (m_ph0 + incr0) & 32'hffff;
        m_ph1 = (m_ph1 + incr1) & 32'hffff;
        chk("seq_valid", valid, 1);
        chk("seq_d0", dout0, m_d0);
        chk("seq_d1", dout1, m_d1);
        chk("seq_busy_end", busy, 0);
        chk("seq_ovr", overrun, m_ovr);
        @(negedge clk);
        chk_idle_outs("seq_after");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);

        // Reset state and idle behaviour.
        @(negedge clk);
        chk("rst_addr", rom_addr, 0);
        chk_idle_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_addr", rom_addr, 0);
        chk_idle_outs("idle5");

        // Basic pair with identity ROM: expect (00,40) then (01,42).
        incr0 = 16'h0100; incr1 = 16'h0200; offset1 = 8'h40;
        seq(0, -1, 0, 0, 0);
        chk("t2_first_d1", dout1, 8'h40);
        seq(0, -1, 0, 0, 0);
        chk("t2_second_d0", dout0, 8'h01);
        chk("t2_second_d1", dout1, 8'h42);
        chk("t2_addr_hold", rom_addr, 8'h42);

        // Accumulator wrap.
        incr0 = 16'h8000; incr1 = 16'h8000; offset1 = 8'hC0;
        seq(1, -1, 0, 0, 0);
        chk("wrap_d0_0", dout0, 8'h00);
        seq(0, -1, 0, 0, 0);
        chk("wrap_d0_1", dout0, 8'h80);
        chk("wrap_d1_1", dout1, 8'h40);
        seq(0, -1, 0, 0, 0);
        chk("wrap_d0_2", dout0, 8'h00);

        // Overrun: dropped tick in A0, then set-vs-clear during C1, then clear alone.
        incr0 = 16'h0100; incr1 = 16'h0300; offset1 = 8'h10;
        seq(0, 0, 0, 0, 0);
        chk("ovr_set", overrun, 1);
        seq(0, 2, 1, 0, 0);
        chk("ovr_set_wins", overrun, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        m_ovr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // en low in idle ignores the tick; en low mid-sequence does not stop it.
        en = 1'b0; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; en = 1'b1;
        chk("en0_busy", busy, 0);
        @(negedge clk);
        chk_idle_outs("en0");
        seq(0, -1, 0, 1, 0);

        // phase_clr while busy is ignored, then honoured with a tick after advances.
        seq(0, -1, 0, 0, 1);
        seq(0, -1, 0, 0, 0);
        seq(1, -1, 0, 0, 0);
        chk("pclr_d0", dout0, 8'h00);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        m_ph0 = 0; m_ph1 = 0;
        seq(0, -1, 0, 0, 0);

        // Reset during A1.
        offset1 = 8'h5A;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        m_ph0 = 0; m_ph1 = 0; m_ovr = 1'b0; m_d0 = '0; m_d1 = '0;
        chk("rst_mid_addr", rom_addr, 0);
        chk_idle_outs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle_outs("rst_mid_quiet");
        end
        seq(0, -1, 0, 0, 0);
        chk("rst_mid_d0", dout0, 8'h00);
        chk("rst_mid_d1", dout1, 8'h5A);

        // Randomized traffic with random ROM contents.
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            int inj;
            incr0   = 16'($urandom);
            incr1   = 16'($urandom);
            offset1 = 8'($urandom);
            inj     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            seq(($urandom_range(0, 7) == 0), inj, ($urandom_range(0, 1) == 1) && inj >= 0,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                clr_overrun = 1'b1;
                @(negedge clk);
                clr_overrun = 1'b0;
                m_ovr = 1'b0;
                chk("rnd_ovr_clr", overrun, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
